// File: rtl/wave_pkg.sv
// ---------------------------------------------------------------------------
// wave_pkg
// Shared definitions for the wavetable address sequencer:
//   - playback mode encodings (MODE_LOOP, MODE_ONESHOT, MODE_PINGPONG;
//     the fourth encoding 2'b11 is reserved and plays as a loop)
//   - default widths used as parameter defaults by wave_channel and
//     wave_sequencer
//   - phase_t, a fixed-point phase at the default widths
//     (integer offset in the upper DEF_LEN_W bits, fraction below)
//   - dir_e, the ping-pong travel direction (only used when the
//     WAVE_PINGPONG_EN macro is defined)
// ---------------------------------------------------------------------------
package wave_pkg;

  localparam logic [1:0] MODE_LOOP     = 2'b00;
  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_LEN_W  = 10;
  localparam int DEF_FRAC_W = 6;
  localparam int DEF_STEP_W = DEF_FRAC_W + 4;
  localparam int DEF_NUM_CH = 4;

  typedef logic [DEF_LEN_W+DEF_FRAC_W-1:0] phase_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/wave_channel.sv
// ---------------------------------------------------------------------------
// wave_channel
// One voice of the wavetable sequencer: holds the fixed-point phase, the
// latched base address, the pending-request flag and the sticky done and
// overrun flags. The phase advances only when the top level issues this
// channel's request.
//
// Optional feature: define WAVE_PINGPONG_EN to give mode 2'b10 a reflecting
// (ping-pong) playback with a per-channel direction register. Without it,
// mode 2'b10 plays as a loop and no direction state exists.
//
// Ports
//   clk, reset_n  clock, asynchronous active-low reset
//   tick          sample strobe
//   enable        channel run enable; low clears the channel, latches base
//   mode          playback mode (see wave_pkg)
//   base          wave start address
//   last          last valid integer offset, inclusive
//   step          phase increment per issued request
//   issue         the top level takes this channel's request this cycle
//   req           a request is available (pending or arriving with tick)
//   addr          base_q + integer part of phase (modulo 2^ADDR_W)
//   done          one-shot finished (sticky)
//   overrun       tick arrived while a request was still pending (sticky)
// ---------------------------------------------------------------------------
module wave_channel
  import wave_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  last,
  input  logic [STEP_W-1:0] step,
  input  logic              issue,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic              done,
  output logic              overrun
);

  localparam int PH_W  = LEN_W + FRAC_W;
  // Two spare bits so sums and the doubled end point never overflow
  localparam int EXT_W = PH_W + 2;

  logic [PH_W-1:0]   phase_q, phase_d;
  logic [ADDR_W-1:0] base_q;
  logic              pending_q, done_q, overrun_q;

  logic              tickReq, restart, doneSet, overrunSet, pendingNext;
  logic [EXT_W-1:0]  phaseX, stepX, lastFix, span, sumUp, wrapped;

`ifdef WAVE_PINGPONG_EN
  dir_e              dir_q, dir_d;
  logic [EXT_W-1:0]  reflect;
`endif

  // A finished one-shot ignores ticks until the channel is disabled
  assign tickReq = enable && tick && !done_q;
  // The tick is offered straight to the picker so that a tick in cycle n
  // can already be in the output register in cycle n+1
  assign req     = enable && (pending_q || tickReq);
  assign restart = (base != base_q);
  assign addr    = base_q + ADDR_W'(phase_q[PH_W-1:FRAC_W]);
  assign done    = done_q;
  assign overrun = overrun_q;

  // Next phase if this channel is issued. "Integer part > last" is
  // evaluated as "phase >= (last+1) << FRAC_W" on the full fixed-point value.
  always_comb begin
    phaseX  = EXT_W'(phase_q);
    stepX   = EXT_W'(step);
    lastFix = EXT_W'(last) << FRAC_W;
    span    = lastFix + (EXT_W'(1) << FRAC_W);
    sumUp   = phaseX + stepX;
    wrapped = sumUp - span;
    phase_d = phase_q;
    doneSet = 1'b0;
`ifdef WAVE_PINGPONG_EN
    dir_d   = dir_q;
    reflect = (lastFix << 1) - sumUp;
`endif
    if (mode == MODE_ONESHOT) begin
      if (sumUp >= span) begin
        doneSet = 1'b1;
      end else begin
        phase_d = PH_W'(sumUp);
      end
`ifdef WAVE_PINGPONG_EN
    end else if (mode == MODE_PINGPONG) begin
      if (dir_q == DIR_UP) begin
        if (sumUp >= span) begin
          // A step larger than a whole span would reflect below zero
          phase_d = (sumUp > (lastFix << 1)) ? '0 : PH_W'(reflect);
          dir_d   = DIR_DOWN;
        end else begin
          phase_d = PH_W'(sumUp);
        end
      end else begin
        if (phaseX >= stepX) begin
          phase_d = PH_W'(phaseX - stepX);
        end else begin
          phase_d = PH_W'(stepX - phaseX);
          dir_d   = DIR_UP;
        end
      end
`endif
    end else begin
      // Loop: wrap once, and if the step still overshoots restart at zero
      if (sumUp < span) begin
        phase_d = PH_W'(sumUp);
      end else if (wrapped < span) begin
        phase_d = PH_W'(wrapped);
      end else begin
        phase_d = '0;
      end
    end
  end

  // At most one request is held: an issue and a tick in the same cycle
  // swap the old request for the new one without flagging an overrun.
  always_comb begin
    overrunSet  = tickReq && pending_q && !issue;
    pendingNext = ((pending_q && tickReq) || ((pending_q || tickReq) && !issue))
                  && !(issue && !restart && doneSet);
  end

  // Channel state; disable clears everything, a base change restarts play
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q   <= '0;
      base_q    <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef WAVE_PINGPONG_EN
      dir_q     <= DIR_UP;
`endif
    end else if (!enable) begin
      phase_q   <= '0;
      base_q    <= base;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef WAVE_PINGPONG_EN
      dir_q     <= DIR_UP;
`endif
    end else begin
      pending_q <= pendingNext;
      if (overrunSet) begin
        overrun_q <= 1'b1;
      end
      if (restart) begin
        base_q  <= base;
        phase_q <= '0;
`ifdef WAVE_PINGPONG_EN
        dir_q   <= DIR_UP;
`endif
      end else if (issue) begin
        phase_q <= phase_d;
        if (doneSet) begin
          done_q <= 1'b1;
        end
`ifdef WAVE_PINGPONG_EN
        dir_q   <= dir_d;
`endif
      end
    end
  end

endmodule

// File: rtl/wave_sequencer.sv
// ---------------------------------------------------------------------------
// wave_sequencer
// Multi-channel wavetable address generator. NUM_CH wave_channel instances
// raise requests on each sample tick; a fixed-priority picker (lowest index
// wins) serialises them into one registered valid/ready read port.
//
// Optional feature: WAVE_PINGPONG_EN (see wave_channel) enables ping-pong
// playback for mode 2'b10.
//
// Ports
//   clk, reset_n  clock, asynchronous active-low reset
//   tick          sample strobe, one cycle wide
//   ch_enable     per-channel run enable           [NUM_CH]
//   ch_mode       per-channel mode, 2 bits each    [2*NUM_CH]
//   ch_base       per-channel start address        [NUM_CH*ADDR_W]
//   ch_last       per-channel last offset          [NUM_CH*LEN_W]
//   ch_step       per-channel phase increment      [NUM_CH*STEP_W]
//   rd_valid      read request present
//   rd_ready      memory accepts the request
//   rd_addr       read address
//   rd_ch         channel owning the request
//   ch_done       sticky one-shot finished flags
//   ch_overrun    sticky overrun flags
// ---------------------------------------------------------------------------
module wave_sequencer
  import wave_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int STEP_W = FRAC_W + 4,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tick,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [2*NUM_CH-1:0]      ch_mode,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base,
  input  logic [NUM_CH*LEN_W-1:0]  ch_last,
  input  logic [NUM_CH*STEP_W-1:0] ch_step,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [CH_W-1:0]          rd_ch,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [NUM_CH-1:0]        ch_overrun
);

  logic [NUM_CH-1:0] req, issue;
  logic [ADDR_W-1:0] chAddr [NUM_CH];

  logic              load, pickValid;
  logic [CH_W-1:0]   pickIdx;
  logic [ADDR_W-1:0] pickAddr;

  logic              rd_valid_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [CH_W-1:0]   rd_ch_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    wave_channel #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W),
      .FRAC_W (FRAC_W),
      .STEP_W (STEP_W)
    ) u_channel (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .enable  (ch_enable[g]),
      .mode    (ch_mode[2*g +: 2]),
      .base    (ch_base[g*ADDR_W +: ADDR_W]),
      .last    (ch_last[g*LEN_W +: LEN_W]),
      .step    (ch_step[g*STEP_W +: STEP_W]),
      .issue   (issue[g]),
      .req     (req[g]),
      .addr    (chAddr[g]),
      .done    (ch_done[g]),
      .overrun (ch_overrun[g])
    );
  end

  // The output register may reload when empty or when its request is taken
  assign load = !rd_valid_q || rd_ready;

  // Lowest-index requesting channel wins; scanning downward lets the last
  // hit (the lowest index) overwrite the earlier ones.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    pickAddr  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        pickValid = 1'b1;
        pickIdx   = CH_W'(i);
        pickAddr  = chAddr[i];
      end
    end
  end

  always_comb begin
    issue = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      issue[i] = load && pickValid && (pickIdx == CH_W'(i));
    end
  end

  // Output register: holds address and channel stable while stalled; a
  // captured request completes regardless of later channel changes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_ch_q    <= '0;
    end else if (load) begin
      rd_valid_q <= pickValid;
      if (pickValid) begin
        rd_addr_q <= pickAddr;
        rd_ch_q   <= pickIdx;
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_addr  = rd_addr_q;
  assign rd_ch    = rd_ch_q;

endmodule
